// File: rtl/fifo_wr_status.sv
// Write-domain status stage for the async FIFO.
// The read-side gray pointer is synchronised into clk_i. The true binary write
// pointer is rebuilt from the lagging gray write pointer. A registered full flag
// is then produced to drive the write counter's forbid input.
// Optional build macro FIFO_WR_LEVEL_EN adds the registered level_o and afull_o.
module fifo_wr_status #(
  parameter int unsigned CNT_WIDTH    = 5,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned AFULL_THRESH = 28
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [CNT_WIDTH:0]   wptr_gray_i,
  input  logic [CNT_WIDTH:0]   rptr_gray_i,
  output logic                 full_o,
  output logic [CNT_WIDTH:0]   rptr_sync_o
`ifdef FIFO_WR_LEVEL_EN
  ,
  output logic                 afull_o,
  output logic [CNT_WIDTH:0]   level_o
`endif
);

  localparam int unsigned PW = CNT_WIDTH + 1;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] rsync;
  logic          wr_acc;
  logic          inc_d, inc_q;
  logic          full_d, full_q;
  logic [PW-1:0] wbin_cur;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rgray_full;

  assign rsync       = sync_q[SYNC_STAGES-1];
  assign rptr_sync_o = rsync;
  assign full_o      = full_q;

  // Plain flop chain carrying the read gray pointer into the write clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= rptr_gray_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // The gray input trails the binary counter by one cycle.
  // inc_q re-adds the write accepted last cycle so wbin_cur matches the counter.
  always_comb begin
    wr_acc     = wr_en_i && !full_q;
    inc_d      = wr_acc;
    wbin_cur   = gray2bin(wptr_gray_i) + PW'(inc_q);
    wbin_next  = wbin_cur + PW'(wr_acc);
    wgray_next = bin2gray(wbin_next);
    rgray_full = {~rsync[CNT_WIDTH:CNT_WIDTH-1], rsync[CNT_WIDTH-2:0]};
    full_d     = (wgray_next == rgray_full);
  end

  // Full flag and accepted-write term registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      inc_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      inc_q  <= inc_d;
    end
  end

`ifdef FIFO_WR_LEVEL_EN
  localparam logic [PW-1:0] AFULL_T = PW'(AFULL_THRESH);

  logic [PW-1:0] level_d, level_q;
  logic          afull_d, afull_q;

  assign level_o = level_q;
  assign afull_o = afull_q;

  // Fill level as seen from the write side; modular subtraction handles pointer wrap.
  always_comb begin
    level_d = wbin_next - gray2bin(rsync);
    afull_d = (level_d >= AFULL_T);
  end

  // Level and almost-full registers, updated in step with full_q.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_q <= '0;
      afull_q <= 1'b0;
    end else begin
      level_q <= level_d;
      afull_q <= afull_d;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_status.sv
// Scoreboard bench for fifo_wr_status.
// The bench plays the write counter and the read side. A queue-based reference
// model pushes the expected outputs for each edge. A monitor on the falling
// edge pops each entry and compares it with the DUT outputs.
module tb_fifo_wr_status;

  localparam int CW    = 5;
  localparam int S     = 2;
  localparam int THR   = 28;
  localparam int DEPTH = 32;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       wr_en_i = 1'b0;
  logic [5:0] wptr_gray_i = '0;
  logic [5:0] rptr_gray_i = '0;
  logic       full_o;
  logic [5:0] rptr_sync_o;
`ifdef FIFO_WR_LEVEL_EN
  logic       afull_o;
  logic [5:0] level_o;
`endif

  fifo_wr_status #(
    .CNT_WIDTH   (CW),
    .SYNC_STAGES (S),
    .AFULL_THRESH(THR)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_en_i    (wr_en_i),
    .wptr_gray_i(wptr_gray_i),
    .rptr_gray_i(rptr_gray_i),
    .full_o     (full_o),
    .rptr_sync_o(rptr_sync_o)
`ifdef FIFO_WR_LEVEL_EN
    ,
    .afull_o    (afull_o),
    .level_o    (level_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit   full;
    bit   afull;
    int   level;
    int   rs;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_mis = 0;

  // Model state: total accepted writes and total reads (no wrap).
  int   wcount, rcount, n_edge;
  int   rd_hist[$];
  bit   exp_full;

  function automatic logic [5:0] bin2gray(input int v);
    logic [5:0] b;
    b = 6'(v % 64);
    return b ^ (b >> 1);
  endfunction

  function automatic int rd_at(input int m);
    return (m < 1) ? 0 : rd_hist[m-1];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: each cycle's expected outputs are checked one half-cycle after the edge.
  always @(negedge clk_i) begin
    if (!rst_i && sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("full", int'(full_o), int'(mon_e.full));
      chk("rptr_sync", int'(rptr_sync_o), mon_e.rs);
`ifdef FIFO_WR_LEVEL_EN
      chk("level", int'(level_o), mon_e.level);
      chk("afull", int'(afull_o), int'(mon_e.afull));
`endif
    end
  end

  task automatic step(input bit we, input bit rd);
    bit   acc;
    int   wprev;
    int   lvl;
    exp_t e;
    wr_en_i = we;
    @(posedge clk_i);
    n_edge++;
    rd_hist.push_back(rcount);
    acc      = we && !exp_full;
    wprev    = wcount;
    wcount  += int'(acc);
    lvl      = wcount - rd_at(n_edge - S);
    exp_full = (lvl == DEPTH);
    e.full   = exp_full;
    e.level  = lvl;
    e.afull  = (lvl >= THR);
    e.rs     = int'(bin2gray(rd_at(n_edge - S + 1)));
    sb.push_back(e);
    #1;
    wptr_gray_i = bin2gray(wprev);
    if (rd && rcount < wcount) rcount++;
    rptr_gray_i = bin2gray(rcount);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_full"}, int'(full_o), 0);
    chk({tag, "_rsync"}, int'(rptr_sync_o), 0);
`ifdef FIFO_WR_LEVEL_EN
    chk({tag, "_level"}, int'(level_o), 0);
    chk({tag, "_afull"}, int'(afull_o), 0);
`endif
  endtask

  task automatic do_reset();
    #2;
    wr_en_i     = 1'($urandom);
    rptr_gray_i = 6'($urandom);
    wptr_gray_i = 6'($urandom);
    rst_i       = 1'b1;
    sb.delete();
    #1;
    chk_zero("rst_async");
    @(posedge clk_i);
    #1;
    chk_zero("rst_held");
    wr_en_i     = 1'b0;
    rptr_gray_i = '0;
    wptr_gray_i = '0;
    @(negedge clk_i);
    rst_i    = 1'b0;
    wcount   = 0;
    rcount   = 0;
    n_edge   = 0;
    exp_full = 1'b0;
    rd_hist.delete();
  endtask

  initial begin
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

    // Fill from empty: only 32 writes are accepted.
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0);
    // Release one slot, then write it again.
    step(1'b0, 1'b1);
    for (int i = 0; i < S + 2; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

    // Random traffic with reads slower than writes, so full is reached often.
    for (int i = 0; i < 800; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));

    // Almost-full threshold, then the simultaneous write and read at level 31.
    do_reset();
    for (int i = 0; i < 27; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < S; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

    // Wrap: the read side trails by a few entries across more than 64 writes.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);

    // Reset in the middle of random traffic.
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

    @(negedge clk_i);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
